// File: rtl/pwm_generator.sv
`default_nettype none
// pwm_generator: single PWM channel stepped by a synchronised div_clk rise (or every
// cycle in bypass), with shadowed period/duty/invert/enable applied at period boundaries.
module pwm_generator #(
  parameter int WIDTH    = 8,
  parameter int SYNC_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             invert_in,
  input  logic             enable_in,
  input  logic             div_clk,
  input  logic             div_bypass,
  output logic             pwm_out,
  output logic             period_done,
  output logic             pending
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [SYNC_LEN-1:0] sync;
  logic                sync_prev;
  logic                step;

  logic [WIDTH-1:0] sh_period;
  logic [WIDTH-1:0] sh_duty;
  logic             sh_invert;
  logic             sh_enable;

  logic [WIDTH-1:0] act_period;
  logic [WIDTH-1:0] act_duty;
  logic             act_invert;
  logic             act_enable;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic             load;
  logic             wrap;
  logic             pwm_next;

  // div_clk is treated purely as data: synchronise, then register the rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= '0;
      sync_prev <= 1'b0;
      step      <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_LEN-2:0], div_clk};
      sync_prev <= sync[SYNC_LEN-1];
      step      <= div_bypass | (sync[SYNC_LEN-1] & ~sync_prev);
    end
  end

  // An idle channel reloads every cycle so a new enable takes effect without waiting for a wrap.
  always_comb begin
    load     = 1'b0;
    wrap     = 1'b0;
    cnt_next = cnt;
    if (!act_enable) begin
      load     = 1'b1;
      cnt_next = '0;
    end else if (step) begin
      if (cnt == act_period) begin
        wrap     = 1'b1;
        load     = 1'b1;
        cnt_next = '0;
      end else begin
        cnt_next = cnt + CNT_ONE;
      end
    end
  end

  always_comb begin
    pwm_next = act_invert;
    if (act_enable) begin
      pwm_next = (cnt_next < act_duty) ^ act_invert;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_period <= '0;
      sh_duty   <= '0;
      sh_invert <= 1'b0;
      sh_enable <= 1'b0;
    end else if (wr) begin
      sh_period <= period_in;
      sh_duty   <= duty_in;
      sh_invert <= invert_in;
      sh_enable <= enable_in;
    end
  end

  // A load takes the shadow contents from before any same-cycle write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_period <= '0;
      act_duty   <= '0;
      act_invert <= 1'b0;
      act_enable <= 1'b0;
    end else if (load) begin
      act_period <= sh_period;
      act_duty   <= sh_duty;
      act_invert <= sh_invert;
      act_enable <= sh_enable;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (wr) begin
      pending <= 1'b1;
    end else if (load) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      pwm_out     <= pwm_next;
      period_done <= wrap;
    end
  end

endmodule
`default_nettype wire
